masku_mask_unpacker: RTL

Mask-unit block that expands a packed mask vector (one bit per element) into per-lane byte-enable strobes, one datapath beat at a time. It is the inverse of the mask-compression path that packs ALU/FPU compare results into mask format. It consumes full mask words from the v0 operand queue and streams element-interleaved byte strobes (element e goes to lane e % NrLanes, slot e / NrLanes) to the lane-facing consumers under a valid/ready handshake.

---
 rtl/masku_mask_unpacker.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/masku_mask_unpacker.sv
// Expands a packed mask vector into per-lane byte strobes, one datapath beat per handshake.
// Element e of a beat goes to lane e % NrLanes, slot e / NrLanes; vsew encodes EW8=0 .. EW64=3.
module masku_mask_unpacker #(
  parameter  int unsigned NrLanes       = 4,
  parameter  int unsigned ELEN          = 64,
  parameter  int unsigned VlWidth       = 16,
  localparam int unsigned DatapathWidth = NrLanes * ELEN,
  localparam int unsigned StrbWidth     = DatapathWidth / 8,
  localparam int unsigned LaneBytes     = ELEN / 8,
  localparam int unsigned PtrWidth      = $clog2(DatapathWidth)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [VlWidth-1:0]       vl_i,
  input  logic [1:0]               vsew_i,
  input  logic                     vm_i,
  input  logic [DatapathWidth-1:0] mask_i,
  input  logic                     mask_valid_i,
  output logic                     mask_ready_o,
  output logic [StrbWidth-1:0]     strb_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     last_o,
  output logic                     busy_o,
  output logic                     done_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MASK,
    EMIT
  } state_e;

  state_e                   state_reg, state_next;
  logic [VlWidth-1:0]       vl_reg, vl_next;
  logic [1:0]               vsew_reg, vsew_next;
  logic                     vm_reg, vm_next;
  logic [DatapathWidth-1:0] mask_reg, mask_next;
  logic [VlWidth-1:0]       elem_cnt_reg, elem_cnt_next;
  logic [PtrWidth-1:0]      bit_ptr_reg, bit_ptr_next;
  logic                     done_reg, done_next;

  // Elements per beat shrinks as elements widen: NrLanes * (8 >> vsew).
  logic [PtrWidth:0] epb;
  logic [VlWidth:0]  elem_sum;
  logic [PtrWidth:0] ptr_sum;
  logic              is_last;
  logic              word_end;

  assign epb      = (PtrWidth+1)'(NrLanes * 8) >> vsew_reg;
  assign elem_sum = {1'b0, elem_cnt_reg} + (VlWidth+1)'(epb);
  assign ptr_sum  = {1'b0, bit_ptr_reg} + epb;
  assign is_last  = elem_sum >= {1'b0, vl_reg};
  assign word_end = ptr_sum == (PtrWidth+1)'(DatapathWidth);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      vl_reg       <= '0;
      vsew_reg     <= '0;
      vm_reg       <= 1'b0;
      mask_reg     <= '0;
      elem_cnt_reg <= '0;
      bit_ptr_reg  <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      vl_reg       <= vl_next;
      vsew_reg     <= vsew_next;
      vm_reg       <= vm_next;
      mask_reg     <= mask_next;
      elem_cnt_reg <= elem_cnt_next;
      bit_ptr_reg  <= bit_ptr_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    vl_next       = vl_reg;
    vsew_next     = vsew_reg;
    vm_next       = vm_reg;
    mask_next     = mask_reg;
    elem_cnt_next = elem_cnt_reg;
    bit_ptr_next  = bit_ptr_reg;
    done_next     = 1'b0;
    mask_ready_o  = 1'b0;
    out_valid_o   = 1'b0;
    last_o        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_i) begin
          vl_next       = vl_i;
          vsew_next     = vsew_i;
          vm_next       = vm_i;
          elem_cnt_next = '0;
          bit_ptr_next  = '0;
          if (vl_i == '0) begin
            done_next = 1'b1;
          end else if (vm_i) begin
            state_next = EMIT;
          end else begin
            state_next = WAIT_MASK;
          end
        end
      end

      WAIT_MASK: begin
        mask_ready_o = 1'b1;
        if (mask_valid_i) begin
          mask_next    = mask_i;
          bit_ptr_next = '0;
          state_next   = EMIT;
        end
      end

      EMIT: begin
        out_valid_o = 1'b1;
        last_o      = is_last;
        if (out_ready_i) begin
          elem_cnt_next = elem_sum[VlWidth-1:0];
          bit_ptr_next  = ptr_sum[PtrWidth-1:0];
          // The final beat wins over a word boundary: leftover mask bits are discarded.
          if (is_last) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else if (!vm_reg && word_end) begin
            state_next = WAIT_MASK;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy_o = state_reg != IDLE;
  assign done_o = done_reg;

  // Each strobe byte maps back to the element slot that owns it at the current width.
  for (genvar gi = 0; gi < NrLanes; gi++) begin : g_lane
    for (genvar gj = 0; gj < LaneBytes; gj++) begin : g_byte
      logic [PtrWidth-1:0] slot_idx;
      logic [VlWidth:0]    elem_idx;
      logic                mask_bit;

      assign slot_idx = PtrWidth'(((gj >> vsew_reg) * NrLanes) + gi);
      assign elem_idx = {1'b0, elem_cnt_reg} + (VlWidth+1)'(slot_idx);
      assign mask_bit = mask_reg[bit_ptr_reg + slot_idx];
      assign strb_o[gi*LaneBytes + gj] = (state_reg == EMIT)
                                         && (elem_idx < {1'b0, vl_reg})
                                         && (vm_reg || mask_bit);
    end
  end

endmodule
